// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch and data requesters.
// Optional conflict performance counter is built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // Handshake: a requester holds req until it sees gnt high in the same cycle;
    // the matching rvalid pulse arrives exactly MEM_LAT cycles after that grant.

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t     state;
    logic [3:0] lat_cnt;
    logic       owner;      // 0 = fetch, 1 = data
    logic       owner_we;
    logic [7:0] starve_cnt;

    logic grant_ok;
    logic f_win;
    logic d_win;
    logic resp;

    always_comb begin
        grant_ok = !rst && !halt_sys && (state == IDLE || state == RESP);
        f_win    = grant_ok && f_req && (!d_req || starve_cnt >= STARVE_LIM);
        d_win    = grant_ok && d_req && !f_win;
        resp     = !rst && (state == RESP);
    end

    assign f_gnt     = f_win;
    assign d_gnt     = d_win;
    assign mem_en    = f_win || d_win;
    assign mem_we    = d_win && d_we;
    assign mem_addr  = f_win ? f_addr : (d_win ? d_addr : '0);
    assign mem_wdata = d_win ? d_wdata : '0;

    assign f_rvalid  = resp && !owner;
    assign d_rvalid  = resp && owner;
    assign f_rdata   = f_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !owner_we) ? mem_rdata : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            owner      <= 1'b0;
            owner_we   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (f_win || d_win) begin
                owner    <= d_win;
                owner_we <= d_win && d_we;
                lat_cnt  <= LAT_INIT;
                state    <= (MEM_LAT == 1) ? RESP : WAIT;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    state <= RESP;
                end
            end else if (state == RESP) begin
                state <= IDLE;
            end

            // Denied fetch cycles count even while halted or waiting.
            if (f_win) begin
                starve_cnt <= '0;
            end else if (f_req && starve_cnt < STARVE_LIM) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] conflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (f_req && d_req && conflict_q != '1) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule
